mem_arbiter: RTL and testbench

Arbiter and sequencer for the single-ported `mem` block, sharing it between the CPU requester (fetcher/decoder data path) and an external requester (program loader / DMA engine). It replaces the ad-hoc testbench multiplexing of address, data and write-enable, so memory can be filled while the CPU runs or stalls. Arbitration uses fixed CPU priority with a starvation guard, plus an optional external bus lock with a timeout.

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer sharing the single-ported mem block between the CPU and an
// external requester: fixed CPU priority, starvation guard, optional bus lock with timeout.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_LIMIT   = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_stall,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic                  ext_lock,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wdata,
    output logic                  ext_gnt,
    output logic                  rvalid_cpu,
    output logic                  rvalid_ext,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  lock_err,
    output logic [1:0]            state_dbg
);

    // Handshake: a requester holds req (with addr/wdata/we stable) until it sees gnt in
    // the same cycle; that grant cycle is the completed access, reads return one cycle later.

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int LW = $clog2(LOCK_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_LIMIT - 1);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] EXT_LOCKED = 2'd1;
    localparam logic [1:0] LOCK_DRAIN = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [SW-1:0]         starve_cnt;
    logic [LW-1:0]         lock_cnt;
    logic                  grant_cpu;
    logic                  grant_ext;
    logic                  lock_timeout;
    logic                  rvalid_cpu_q;
    logic                  rvalid_ext_q;
    logic                  lock_err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;

    always_comb begin
        grant_cpu = 1'b0;
        grant_ext = 1'b0;
        if (!reset) begin
            if (state == EXT_LOCKED) begin
                grant_ext = ext_req;
            end else if (ext_req && starve_cnt == STARVE_MAX) begin
                grant_ext = 1'b1;
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end else if (ext_req) begin
                grant_ext = 1'b1;
            end
        end
    end

    assign cpu_gnt   = grant_cpu;
    assign ext_gnt   = grant_ext;
    assign cpu_stall = cpu_req & ~grant_cpu;

    // Without a grant the address/data lines hold the last issued access.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = addr_q;
        mem_din  = din_q;
        if (reset) begin
            mem_addr = '0;
            mem_din  = '0;
        end else if (grant_cpu) begin
            mem_we   = cpu_we;
            mem_addr = cpu_addr;
            mem_din  = cpu_wdata;
        end else if (grant_ext) begin
            mem_we   = ext_we;
            mem_addr = ext_addr;
            mem_din  = ext_wdata;
        end
    end

    assign lock_timeout = (state == EXT_LOCKED) && ext_lock && ext_req && (lock_cnt == LOCK_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_ext && ext_lock) state_next = EXT_LOCKED;
            end
            EXT_LOCKED: begin
                if (!ext_lock || !ext_req) state_next = IDLE;
                else if (lock_cnt == LOCK_LAST) state_next = LOCK_DRAIN;
            end
            LOCK_DRAIN: begin
                if (!ext_lock) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            lock_cnt     <= '0;
            lock_err_q   <= 1'b0;
            rvalid_cpu_q <= 1'b0;
            rvalid_ext_q <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
        end else begin
            state <= state_next;

            // Lock counter is zero outside EXT_LOCKED, so every new tenure starts from 0.
            if (state == EXT_LOCKED && state_next == EXT_LOCKED) lock_cnt <= lock_cnt + 1'b1;
            else lock_cnt <= '0;

            if (!ext_req || grant_ext) starve_cnt <= '0;
            else if (grant_cpu && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;

            lock_err_q   <= lock_err_q | lock_timeout;
            rvalid_cpu_q <= grant_cpu & ~cpu_we;
            rvalid_ext_q <= grant_ext & ~ext_we;

            if (grant_cpu || grant_ext) begin
                addr_q <= mem_addr;
                din_q  <= mem_din;
            end
        end
    end

    // A reset cycle drops any pending read response immediately.
    assign rvalid_cpu = rvalid_cpu_q & ~reset;
    assign rvalid_ext = rvalid_ext_q & ~reset;
    assign lock_err   = lock_err_q & ~reset;
    assign rdata      = mem_dout;
    assign state_dbg  = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, cycle reference model
// built from the arbitration rules, and directed plus randomized scenarios.
module tb_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int LOCK_LIMIT   = 64;
    localparam logic [15:0] INSTRUCTION_BASE = 16'h0400;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        cpu_req, cpu_we, ext_req, ext_we, ext_lock;
    logic [15:0] cpu_addr, ext_addr, mem_addr;
    logic [7:0]  cpu_wdata, ext_wdata, rdata, mem_din, mem_dout;
    logic        cpu_gnt, cpu_stall, ext_gnt, rvalid_cpu, rvalid_ext, mem_we, lock_err;
    logic [1:0]  state_dbg;

    mem_arbiter #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .STARVE_LIMIT(STARVE_LIMIT), .LOCK_LIMIT(LOCK_LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt),
        .rvalid_cpu(rvalid_cpu), .rvalid_ext(rvalid_ext), .rdata(rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .lock_err(lock_err), .state_dbg(state_dbg)
    );

    // behavioural single-ported memory with registered read data
    logic [7:0] mem_arr [0:65535];
    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_addr] <= mem_din;
        mem_dout <= mem_arr[mem_addr];
    end

    // reference model state
    logic [7:0] mem_m [0:65535];
    logic [7:0] exp_q [$];
    int   starve_run;
    bit   lock_held, lock_stuck, err_m, pend_cpu, pend_ext;
    int   lock_cycles;
    logic [15:0] last_addr;
    logic [7:0]  last_din;

    int checks = 0;
    int failures = 0;

    logic [38:0] exp_v, obs_v;
    logic        o_cpu_gnt, o_ext_gnt, o_stall, o_mem_we, o_rv_cpu, o_rv_ext, o_lock_err;
    logic [15:0] o_mem_addr;
    logic [7:0]  o_mem_din, o_rdata;

    // driver: apply one cycle of inputs, sample outputs mid-cycle, advance the model
    task automatic drive(input bit rst, input bit c_req, input bit c_we, input logic [15:0] c_addr,
                         input logic [7:0] c_wd, input bit e_req, input bit e_we, input bit e_lock,
                         input logic [15:0] e_addr, input logic [7:0] e_wd);
        bit g_cpu, g_ext, ewe;
        logic [15:0] ea;
        logic [7:0] ed, e_rdata, d;
        @(negedge clk);
        reset = rst; cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
        ext_req = e_req; ext_we = e_we; ext_lock = e_lock; ext_addr = e_addr; ext_wdata = e_wd;
        g_cpu = 0;
        g_ext = 0;
        if (!rst) begin
            if (lock_held) g_ext = e_req;
            else if (e_req && starve_run == STARVE_LIMIT) g_ext = 1;
            else if (c_req) g_cpu = 1;
            else if (e_req) g_ext = 1;
        end
        e_rdata = 8'h00;
        if (pend_cpu || pend_ext) begin
            d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            if (!rst) e_rdata = d;
        end
        if (rst) begin ea = 16'h0; ed = 8'h0; end
        else if (g_cpu) begin ea = c_addr; ed = c_wd; end
        else if (g_ext) begin ea = e_addr; ed = e_wd; end
        else begin ea = last_addr; ed = last_din; end
        ewe = g_cpu ? c_we : (g_ext ? e_we : 1'b0);
        exp_v = {g_cpu, g_ext, c_req & !g_cpu, ewe, pend_cpu & !rst, pend_ext & !rst,
                 err_m & !rst, ea, ed, e_rdata};
        #2;
        o_cpu_gnt = cpu_gnt; o_ext_gnt = ext_gnt; o_stall = cpu_stall; o_mem_we = mem_we;
        o_rv_cpu = rvalid_cpu; o_rv_ext = rvalid_ext; o_lock_err = lock_err;
        o_mem_addr = mem_addr; o_mem_din = mem_din; o_rdata = rdata;
        obs_v = {o_cpu_gnt, o_ext_gnt, o_stall, o_mem_we, o_rv_cpu, o_rv_ext, o_lock_err,
                 o_mem_addr, o_mem_din, (o_rv_cpu | o_rv_ext) ? o_rdata : 8'h00};
        @(posedge clk);
        if (rst) begin
            starve_run = 0; lock_held = 0; lock_stuck = 0; lock_cycles = 0; err_m = 0;
            pend_cpu = 0; pend_ext = 0; last_addr = 16'h0; last_din = 8'h0;
        end else begin
            pend_cpu = g_cpu && !c_we;
            pend_ext = g_ext && !e_we;
            if (g_cpu || g_ext) begin
                last_addr = ea;
                last_din = ed;
                if (ewe) mem_m[ea] = ed;
                else exp_q.push_back(mem_m[ea]);
            end
            if (!e_req || g_ext) starve_run = 0;
            else if (g_cpu && starve_run < STARVE_LIMIT) starve_run++;
            if (lock_held) begin
                if (!e_lock || !e_req) lock_held = 0;
                else if (lock_cycles == LOCK_LIMIT - 1) begin
                    lock_held = 0; lock_stuck = 1; err_m = 1;
                end else lock_cycles++;
            end else if (lock_stuck) begin
                if (!e_lock) lock_stuck = 0;
            end else if (g_ext && e_lock) begin
                lock_held = 1; lock_cycles = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 16'h1234, 8'h55, 1, 1, 1, 16'h4321, 8'hAA);
            checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL reset_vec cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            checks++;
            if ({o_cpu_gnt, o_ext_gnt, o_mem_we, o_mem_addr, o_mem_din} !== 27'h0) begin
                failures++; $display("FAIL reset_outputs got gnt=%b/%b we=%b addr=%h din=%h exp 0",
                                     o_cpu_gnt, o_ext_gnt, o_mem_we, o_mem_addr, o_mem_din);
            end
        end
        idle(1);
    endtask

    task automatic test_write_read();
        drive(0, 0, 0, 0, 0, 1, 1, 0, 16'h0010, 8'hA5);
        checks++;
        if (obs_v !== exp_v || o_ext_gnt !== 1'b1) begin
            failures++; $display("FAIL wr_ext got=%h exp=%h", obs_v, exp_v);
        end
        drive(0, 1, 0, 16'h0010, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_v !== exp_v || o_cpu_gnt !== 1'b1) begin
            failures++; $display("FAIL rd_cpu_gnt got=%h exp=%h", obs_v, exp_v);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (o_rv_cpu !== 1'b1 || o_rdata !== 8'hA5) begin
            failures++; $display("FAIL rd_data got rvalid=%b rdata=%h exp 1/a5", o_rv_cpu, o_rdata);
        end
    endtask

    task automatic test_starvation();
        idle(1);
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 0, 16'(16'h0020 + i), 0, 1, 0, 0, 16'(16'h0040 + i), 0);
            checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL starve_vec cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            checks++;
            if (o_cpu_gnt !== (i % 5 != 4) || o_stall !== (i % 5 == 4)) begin
                failures++; $display("FAIL starve_pattern cyc=%0d got gnt=%b stall=%b exp gnt=%b",
                                     i, o_cpu_gnt, o_stall, (i % 5 != 4));
            end
        end
        idle(1);
    endtask

    task automatic test_lock();
        logic [7:0] wr [8];
        logic [7:0] wd;
        int k = 0;
        int blocked = 0;
        bit started = 0;
        idle(1);
        for (int i = 0; i < 40 && k < 8; i++) begin
            wd = 8'($urandom);
            drive(0, 1, 0, 16'h0300, 0, 1, 1, (k != 7), 16'(16'h0200 + k), wd);
            checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL lock_vec cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            if (o_ext_gnt === 1'b1) begin wr[k] = wd; k++; started = 1; end
            if (started && o_cpu_gnt !== 1'b1) blocked++;
        end
        checks++;
        if (k != 8 || blocked != 8) begin
            failures++; $display("FAIL lock_blocked got writes=%0d blocked=%0d exp 8/8", k, blocked);
        end
        drive(0, 1, 0, 16'h0300, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_v !== exp_v || o_cpu_gnt !== 1'b1) begin
            failures++; $display("FAIL lock_release got cpu_gnt=%b exp 1", o_cpu_gnt);
        end
        for (int j = 0; j <= 8; j++) begin
            drive(0, (j < 8), 0, 16'(16'h0200 + j), 0, 0, 0, 0, 0, 0);
            checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL lock_rd_vec j=%0d got=%h exp=%h", j, obs_v, exp_v);
            end
            if (j > 0) begin
                checks++;
                if (o_rv_cpu !== 1'b1 || o_rdata !== wr[j-1]) begin
                    failures++; $display("FAIL lock_rd_data j=%0d got=%h exp=%h", j, o_rdata, wr[j-1]);
                end
            end
        end
    endtask

    task automatic test_lock_timeout();
        int drain_cpu = 0;
        idle(1);
        for (int i = 0; i <= LOCK_LIMIT + 20; i++) begin
            drive(0, (i > 0), 0, 16'h0500, 0, 1, 1, 1, 16'h0600, 8'($urandom));
            checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL tmo_vec cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            if (i >= 1 && i <= LOCK_LIMIT) begin
                checks++;
                if (o_cpu_gnt !== 1'b0 || o_lock_err !== 1'b0) begin
                    failures++; $display("FAIL tmo_locked cyc=%0d got gnt=%b err=%b exp 0/0",
                                         i, o_cpu_gnt, o_lock_err);
                end
            end
            if (i == LOCK_LIMIT + 1) begin
                checks++;
                if (o_lock_err !== 1'b1 || o_cpu_gnt !== 1'b1) begin
                    failures++; $display("FAIL tmo_err got err=%b gnt=%b exp 1/1", o_lock_err, o_cpu_gnt);
                end
            end
            if (i > LOCK_LIMIT && o_cpu_gnt === 1'b1) drain_cpu++;
        end
        checks++;
        if (drain_cpu != 16) begin
            failures++; $display("FAIL tmo_drain got cpu_grants=%0d exp 16", drain_cpu);
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 16'h0500, 0, 1, 0, 0, 16'h0600, 0);
            checks++;
            if (obs_v !== exp_v || o_lock_err !== 1'b1) begin
                failures++; $display("FAIL tmo_after cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
        end
        idle(1);
    endtask

    task automatic test_reset_mid_read();
        drive(0, 1, 0, 16'h0010, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_v !== exp_v) begin
            failures++; $display("FAIL rmr_grant got=%h exp=%h", obs_v, exp_v);
        end
        drive(1, 1, 0, 16'h0011, 8'h3C, 1, 1, 1, 16'h0012, 8'hC3);
        checks++;
        if (obs_v !== exp_v || o_rv_cpu !== 1'b0 || o_lock_err !== 1'b0 || o_mem_addr !== 16'h0
            || o_mem_din !== 8'h0 || o_mem_we !== 1'b0 || o_cpu_gnt !== 1'b0 || o_ext_gnt !== 1'b0) begin
            failures++; $display("FAIL rmr_reset got=%h exp=%h", obs_v, exp_v);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_v !== exp_v || o_rv_cpu !== 1'b0) begin
            failures++; $display("FAIL rmr_after got=%h exp=%h", obs_v, exp_v);
        end
    endtask

    task automatic test_program_load();
        logic [7:0] prog [16];
        idle(1);
        for (int k = 0; k < 16; k++) begin
            prog[k] = 8'($urandom);
            drive(0, 0, 0, 0, 0, 1, 1, (k != 15), 16'(INSTRUCTION_BASE + k), prog[k]);
            checks++;
            if (obs_v !== exp_v || o_ext_gnt !== 1'b1) begin
                failures++; $display("FAIL load_vec k=%0d got=%h exp=%h", k, obs_v, exp_v);
            end
        end
        for (int k = 0; k <= 16; k++) begin
            drive(0, (k < 16), 0, 16'(INSTRUCTION_BASE + k), 0, 0, 0, 0, 0, 0);
            checks++;
            if (obs_v !== exp_v || o_ext_gnt !== 1'b0) begin
                failures++; $display("FAIL fetch_vec k=%0d got=%h exp=%h", k, obs_v, exp_v);
            end
            if (k > 0) begin
                checks++;
                if (o_rv_cpu !== 1'b1 || o_rdata !== prog[k-1]) begin
                    failures++; $display("FAIL fetch_data k=%0d got=%h exp=%h", k, o_rdata, prog[k-1]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit lk = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) lk = ~lk;
            drive(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'(16'h0800 + $urandom_range(0, 15)), 8'($urandom),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), lk,
                  16'(16'h0800 + $urandom_range(0, 15)), 8'($urandom));
            checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL random_vec cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ext_req = 0; ext_we = 0; ext_lock = 0; ext_addr = 0; ext_wdata = 0;
        for (int a = 0; a < 65536; a++) begin
            mem_arr[a] = 8'h00;
            mem_m[a] = 8'h00;
        end
        starve_run = 0; lock_held = 0; lock_stuck = 0; lock_cycles = 0; err_m = 0;
        pend_cpu = 0; pend_ext = 0; last_addr = 0; last_din = 0;
        test_reset();
        test_write_read();
        test_starvation();
        test_lock();
        test_lock_timeout();
        test_reset_mid_read();
        test_program_load();
        test_random();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog expired at time %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
